mce_encrypt: RTL and testbench
==============================

MCE_ENCRYPT -- requirements
Module: mce_encrypt

Interface
REQ-001 Parameter Q, default 2, prime q; n = Q*Q.
REQ-002 Parameter T, default 1, correctable errors; N = 2*T*Q, K = n + N.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  request encryption; sampled in IDLE only.
REQ-006 msg  input  n  plaintext m; captured on accepted start.
REQ-007 err  input  K  error vector e; captured on accepted start.
REQ-008 key_valid  input  1  qualifies key_col for the current cycle.
REQ-009 key_col  input  n  one public-key column of G' (n x K), highest column index first.
REQ-010 busy  output  1  high from accepted start until ct_valid.
REQ-011 ct  output  K  ciphertext c = m*G' xor e; bit i corresponds to column i.
REQ-012 ct_valid  output  1  one-cycle pulse; ct is stable from this cycle until the next accepted start.
REQ-013 err_flag  output  1  high with ct_valid when weight(e) != T; held until the next accepted start.

Function
REQ-014 FSM states: IDLE, RCV_KEY, DONE.
REQ-015 IDLE: start=1 captures msg/err, clears the ct accumulator, sets col_idx=K-1 and wcnt=0, sets busy, and moves to RCV_KEY.
REQ-016 IDLE: start=0 holds state; key_valid is ignored.
REQ-017 RCV_KEY, key_valid=1: ct[col_idx] <= (^(m & key_col)) xor e[col_idx]; wcnt += e[col_idx]; col_idx decrements.
REQ-018 RCV_KEY, key_valid=0: no state change, so stalls of any length are allowed.
REQ-019 RCV_KEY: accepting column 0 moves to DONE.
REQ-020 DONE: for exactly one cycle, ct_valid=1, err_flag=(wcnt != T), busy=0; the next state is IDLE.
REQ-021 Latency: ct_valid occurs 1 cycle after the cycle that accepts column 0; with no stalls, start-to-ct_valid is K+2 cycles.
REQ-022 start is ignored while busy=1 or in DONE; captured msg/err are not overwritten.
REQ-023 key_valid in DONE or IDLE is dropped.
REQ-024 col_idx width is clog2(K); wcnt width is clog2(K+1); no wrap occurs because the FSM leaves RCV_KEY at index 0.
REQ-025 Parity: XOR-reduction of an n-bit AND (GF(2) dot product); no carry arithmetic.
REQ-026 A K-column burst with key_valid held high at 1 column/cycle is accepted without loss.

Reset
REQ-027 Asynchronous reset forces state=IDLE, busy=0, ct_valid=0, err_flag=0, ct=0, col_idx=0, wcnt=0.
REQ-028 Reset asserted mid-RCV_KEY abandons the operation; no ct_valid is produced.
REQ-029 After reset deassertion, the first accepted start behaves identically to a fresh start.

Structure
REQ-030 Q, T and the derived n, N, K live in the shared parameter header used by the key-generation block, so both ends agree on the widths.
REQ-031 State encodings are local constants.
REQ-032 One natural sub-module: mce_col_dot (combinational n-bit AND + XOR reduce), reusable for decoding syndrome work.

Verification (Q=2, T=1: n=4, K=8; column i of G' = 4'b0001 << (i%4) unless stated)
REQ-033 msg=4'b1010, err=8'h01, 8 columns back-to-back -> ct=8'hAB, err_flag=0, ct_valid exactly at cycle K+2 after start.
REQ-034 msg=4'b0000, err=8'h03 -> ct=8'h03, err_flag=1.
REQ-035 Test of REQ-033 with key_valid deasserted for 3 cycles after column 4 -> same ct=8'hAB; ct_valid delayed by 3 cycles.
REQ-036 start pulsed again while busy with msg=4'hF -> ignored; result still 8'hAB; busy stays continuous.
REQ-037 Reset asserted after column 5 -> all outputs 0 immediately; no ct_valid; a following clean run gives 8'hAB.
REQ-038 All columns 4'hF, msg=4'b0111, err=8'h80 -> ct=8'h7F, err_flag=0.

Source files
------------

// File: rtl/mce_encrypt_pkg.sv
// Shared McEliece parameters and encryptor state type.
// The key-generation block uses the same header, so both ends agree on the widths.
package mce_encrypt_pkg;

  localparam int unsigned Q_DEFAULT = 2;  // prime q
  localparam int unsigned T_DEFAULT = 1;  // correctable errors

  // Message length n = q*q
  function automatic int unsigned msg_bits(input int unsigned q);
    return q * q;
  endfunction

  // Code length K = n + 2*t*q
  function automatic int unsigned code_bits(input int unsigned q, input int unsigned t);
    return q * q + 2 * t * q;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RCV_KEY = 2'd1,
    ST_DONE    = 2'd2
  } mce_state_e;

endpackage

// File: rtl/mce_encrypt_col_dot.sv
// GF(2) dot product of two n-bit vectors: AND followed by XOR reduction.
// It is also reusable for syndrome computation on the decode side.
module mce_col_dot #(
  parameter int unsigned N_BITS = 4
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              p
);

  // Parity of the bitwise product; there is no carry arithmetic
  always_comb begin
    p = ^(a & b);
  end

endmodule

// File: rtl/mce_encrypt.sv
// McEliece encryptor: c = m*G' xor e.
// G' arrives one column per key_valid, highest column index first.
module mce_encrypt
  import mce_encrypt_pkg::*;
#(
  parameter int unsigned Q = Q_DEFAULT,
  parameter int unsigned T = T_DEFAULT,
  localparam int unsigned NM = msg_bits(Q),
  localparam int unsigned K  = code_bits(Q, T)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NM-1:0] msg,
  input  logic [K-1:0]  err,
  input  logic          key_valid,
  input  logic [NM-1:0] key_col,
  output logic          busy,
  output logic [K-1:0]  ct,
  output logic          ct_valid,
  output logic          err_flag
);

  localparam int unsigned CW  = $clog2(K);
  localparam int unsigned WCW = $clog2(K + 1);

  mce_state_e     state_q, state_d;
  logic [NM-1:0]  msg_q, msg_d;
  logic [K-1:0]   err_q, err_d;
  logic [K-1:0]   ct_q, ct_d;
  logic [CW-1:0]  col_idx_q, col_idx_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           busy_q, busy_d;
  logic           ct_valid_q, ct_valid_d;
  logic           err_flag_q, err_flag_d;

  logic           dot_bit;
  logic           e_bit;
  logic [WCW-1:0] wcnt_inc;

  mce_col_dot #(
    .N_BITS(NM)
  ) u_col_dot (
    .a(msg_q),
    .b(key_col),
    .p(dot_bit)
  );

  // Next-state and output logic; outputs are registered on the transitions into each state
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    err_d      = err_q;
    ct_d       = ct_q;
    col_idx_d  = col_idx_q;
    wcnt_d     = wcnt_q;
    busy_d     = busy_q;
    ct_valid_d = 1'b0;
    err_flag_d = err_flag_q;
    e_bit      = err_q[col_idx_q];
    wcnt_inc   = wcnt_q + WCW'(e_bit);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d      = msg;
          err_d      = err;
          ct_d       = '0;
          col_idx_d  = CW'(K - 1);
          wcnt_d     = '0;
          busy_d     = 1'b1;
          err_flag_d = 1'b0;
          state_d    = ST_RCV_KEY;
        end
      end
      ST_RCV_KEY: begin
        if (key_valid) begin
          ct_d[col_idx_q] = dot_bit ^ e_bit;
          wcnt_d          = wcnt_inc;
          // Column 0 is the last one, so the index never wraps
          if (col_idx_q == '0) begin
            busy_d     = 1'b0;
            ct_valid_d = 1'b1;
            err_flag_d = (wcnt_inc != WCW'(T));
            state_d    = ST_DONE;
          end else begin
            col_idx_d = col_idx_q - CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      msg_q      <= '0;
      err_q      <= '0;
      ct_q       <= '0;
      col_idx_q  <= '0;
      wcnt_q     <= '0;
      busy_q     <= 1'b0;
      ct_valid_q <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      err_q      <= err_d;
      ct_q       <= ct_d;
      col_idx_q  <= col_idx_d;
      wcnt_q     <= wcnt_d;
      busy_q     <= busy_d;
      ct_valid_q <= ct_valid_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Drive the outputs straight from the flops
  always_comb begin
    busy     = busy_q;
    ct       = ct_q;
    ct_valid = ct_valid_q;
    err_flag = err_flag_q;
  end

endmodule

// File: tb/tb_mce_encrypt.sv
// Directed bench for mce_encrypt at Q=2, T=1 (n=4, K=8).
module tb_mce_encrypt;

  localparam int K = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] msg;
  logic [7:0] err;
  logic       key_valid;
  logic [3:0] key_col;
  logic       busy;
  logic [7:0] ct;
  logic       ct_valid;
  logic       err_flag;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  mce_encrypt #(
    .Q(2),
    .T(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .msg      (msg),
    .err      (err),
    .key_valid(key_valid),
    .key_col  (key_col),
    .busy     (busy),
    .ct       (ct),
    .ct_valid (ct_valid),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full encryption; columns are 1<<(i%4) or all-ones
  task automatic do_run(input string tag, input logic [3:0] m, input logic [7:0] e,
                        input bit allf, input int stall_at, input int stall_len,
                        input bit restart, input logic [7:0] exp_ct,
                        input bit exp_flag, input int exp_lat);
    int         start_cyc;
    bit         busy_ok;
    bit         seen;
    logic [3:0] one;
    logic [7:0] ct_seen;
    logic       flag_seen;
    one     = 4'b0001;
    busy_ok = 1'b1;
    seen    = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    msg       = m;
    err       = e;
    key_valid = 1'b0;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    msg   = ~m;
    err   = ~e;
    for (int col = K - 1; col >= 0; col--) begin
      key_valid = 1'b1;
      key_col   = allf ? 4'hF : (one << (col % 4));
      if (restart && col == 5) begin
        start = 1'b1;
        msg   = 4'hF;
      end
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (col == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          key_valid = 1'b0;
          key_col   = 4'hF;
          @(negedge clk);
          if (!busy) busy_ok = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    key_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ct_valid) seen = 1'b1;
    end
    check_eq({tag, " ct_valid seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(cyc - start_cyc + 1), 32'(exp_lat));
    check_eq({tag, " ct"}, 32'(ct), 32'(exp_ct));
    check_eq({tag, " err_flag"}, 32'(err_flag), 32'(exp_flag));
    check_eq({tag, " busy low at valid"}, 32'(busy), 32'd0);
    check_eq({tag, " busy continuous"}, 32'(busy_ok), 32'd1);
    ct_seen   = ct;
    flag_seen = err_flag;
    @(negedge clk);
    check_eq({tag, " ct_valid pulse"}, 32'(ct_valid), 32'd0);
    check_eq({tag, " ct held"}, 32'(ct), 32'(ct_seen));
    check_eq({tag, " err_flag held"}, 32'(err_flag), 32'(flag_seen));
  endtask

  initial begin
    logic [3:0] one;
    bit         got_valid;
    one       = 4'b0001;
    reset     = 1'b1;
    start     = 1'b0;
    msg       = '0;
    err       = '0;
    key_valid = 1'b0;
    key_col   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset ct", 32'(ct), 32'd0);
    check_eq("reset ct_valid", 32'(ct_valid), 32'd0);
    check_eq("reset err_flag", 32'(err_flag), 32'd0);
    reset = 1'b0;

    // key_valid in IDLE must be dropped
    key_valid = 1'b1;
    key_col   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    key_valid = 1'b0;
    check_eq("idle key busy", 32'(busy), 32'd0);
    check_eq("idle key ct", 32'(ct), 32'd0);

    do_run("basic", 4'b1010, 8'h01, 1'b0, -1, 0, 1'b0, 8'hAB, 1'b0, K + 2);
    do_run("weight2", 4'b0000, 8'h03, 1'b0, -1, 0, 1'b0, 8'h03, 1'b1, K + 2);
    do_run("stall", 4'b1010, 8'h01, 1'b0, 4, 3, 1'b0, 8'hAB, 1'b0, K + 5);
    do_run("restart", 4'b1010, 8'h01, 1'b0, -1, 0, 1'b1, 8'hAB, 1'b0, K + 2);

    // Reset in the middle of key reception, after column 5
    @(posedge clk); #1;
    start = 1'b1;
    msg   = 4'b1010;
    err   = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    for (int col = 7; col >= 5; col--) begin
      key_valid = 1'b1;
      key_col   = one << (col % 4);
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    check_eq("midrun partial ct", 32'(ct), 32'h000000A0);
    check_eq("midrun busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrun reset busy", 32'(busy), 32'd0);
    check_eq("midrun reset ct", 32'(ct), 32'd0);
    check_eq("midrun reset ct_valid", 32'(ct_valid), 32'd0);
    check_eq("midrun reset err_flag", 32'(err_flag), 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    got_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_valid = 1'b1;
      key_col   = 4'hF;
      @(negedge clk);
      if (ct_valid) got_valid = 1'b1;
    end
    key_valid = 1'b0;
    check_eq("abandoned no ct_valid", 32'(got_valid), 32'd0);
    check_eq("abandoned busy", 32'(busy), 32'd0);

    do_run("after reset", 4'b1010, 8'h01, 1'b0, -1, 0, 1'b0, 8'hAB, 1'b0, K + 2);
    do_run("all ones", 4'b0111, 8'h80, 1'b1, -1, 0, 1'b0, 8'h7F, 1'b0, K + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
